sseg_scan_mux: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It consumes the central FSM's `state` code and the three pet statistics and scans them onto the shared segment bus one digit at a time. It replaces the single-digit static drive at the top level. Inputs are snapshotted once per frame so a value change never tears across digits.

---
 rtl/sseg_scan_mux.sv | 137 +++++++++++++
 tb/tb_sseg_scan_mux.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
// Four-digit multiplexed seven-segment driver (state + three pet stats), active-low segments and anodes.
// Optional blinking of zero-valued stat digits is enabled by defining SSEG_BLINK_EN.
module sseg_scan_mux #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [2:0] energy,
    input  logic [2:0] hunger,
    input  logic [2:0] entertainment,
    output logic [0:6] sseg,
    output logic [3:0] an
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);

    logic [TW-1:0] tick_cnt;
    logic [1:0]    digit;
    logic [3:0]    snap_state;
    logic [2:0]    snap_energy;
    logic [2:0]    snap_hunger;
    logic [2:0]    snap_entertainment;
    logic          frame_end;
    logic [3:0]    digit_val;
    logic          slot_dark;

    function automatic logic [0:6] glyph(input logic [3:0] v);
        logic [0:6] g;
        g = 7'b1111111;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            4'hF: g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    assign frame_end = (tick_cnt == TICK_LAST) && (digit == 2'd3);

    always_comb begin
        digit_val = snap_state;
        case (digit)
            2'd1:    digit_val = {1'b0, snap_energy};
            2'd2:    digit_val = {1'b0, snap_hunger};
            2'd3:    digit_val = {1'b0, snap_entertainment};
            default: digit_val = snap_state;
        endcase
    end

`ifdef SSEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    // Phase flips every BLINK_FRAMES frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        slot_dark = 1'b0;
        if (blink_phase && (digit != 2'd0) && (digit_val == 4'd0))
            slot_dark = 1'b1;
    end
`else
    always_comb begin
        slot_dark = 1'b0;
    end
`endif

    // Inputs are captured only at the frame boundary so one frame never mixes old and new values
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt           <= '0;
            digit              <= 2'd0;
            snap_state         <= 4'd0;
            snap_energy        <= 3'd0;
            snap_hunger        <= 3'd0;
            snap_entertainment <= 3'd0;
        end else begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (frame_end) begin
                snap_state         <= state;
                snap_energy        <= energy;
                snap_hunger        <= hunger;
                snap_entertainment <= entertainment;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (tick_cnt < BLANK_END) || slot_dark) begin
            an   <= 4'b1111;
            sseg <= 7'b1111111;
        end else begin
            an   <= ~(4'b0001 << digit);
            sseg <= glyph(digit_val);
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomised self-checking bench for sseg_scan_mux against a position-based display model.
// Runs with SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2; honours SSEG_BLINK_EN when defined.
module tb_sseg_scan_mux;

    localparam int D  = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * D;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state = 4'd0;
    logic [2:0] energy = 3'd0;
    logic [2:0] hunger = 3'd0;
    logic [2:0] entertainment = 3'd0;
    logic [0:6] sseg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    int         pos = 0;
    int         shown [4] = '{0, 0, 0, 0};
    logic [3:0] exp_an = 4'hF;
    logic [6:0] exp_sseg = 7'h7F;

    sseg_scan_mux #(
        .SCAN_DIV    (D),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .energy       (energy),
        .hunger       (hunger),
        .entertainment(entertainment),
        .sseg         (sseg),
        .an           (an)
    );

    always #5 clk = ~clk;

    // Reference: display content follows purely from the cycle position since reset
    always @(posedge clk) begin
        int  t, d, fr, v;
        bit  dark;
        if (rst) begin
            pos      = 0;
            shown    = '{0, 0, 0, 0};
            exp_an   = 4'hF;
            exp_sseg = 7'h7F;
        end else begin
            t    = pos % D;
            d    = (pos / D) % 4;
            fr   = pos / FRAME;
            v    = shown[d];
            dark = (t < BC);
`ifdef SSEG_BLINK_EN
            if (((fr / BF) % 2) == 1 && d != 0 && v == 0) dark = 1'b1;
`endif
            if (dark) begin
                exp_an   = 4'hF;
                exp_sseg = 7'h7F;
            end else begin
                exp_an   = 4'hF ^ (4'b0001 << d);
                exp_sseg = GLYPH[v];
            end
            if (t == D - 1 && d == 3) begin
                shown[0] = int'(state);
                shown[1] = int'(energy);
                shown[2] = int'(hunger);
                shown[3] = int'(entertainment);
            end
            pos = pos + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || sseg !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL reset_hold an=%b sseg=%b expected an=1111 sseg=1111111", an, sseg);
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (k < 3 && (an !== 4'hF || sseg !== 7'h7F)) begin
                errors++;
                $display("[TB] FAIL reset_blank edge=%0d an=%b sseg=%b expected an=1111 sseg=1111111", k, an, sseg);
            end
            if (k == 3 && (an !== 4'b1110 || sseg !== 7'b0000001)) begin
                errors++;
                $display("[TB] FAIL reset_first_digit an=%b sseg=%b expected an=1110 sseg=0000001", an, sseg);
            end
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] lit_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] lit_seg [4] = '{7'b0001000, 7'b0100100, 7'b0010010, 7'b0001111};
        int p, t, d;
        state = 4'hA; energy = 3'd5; hunger = 3'd2; entertainment = 3'd7;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || sseg !== exp_sseg) begin
                errors++;
                $display("[TB] FAIL scan_model pos=%0d an=%b sseg=%b expected an=%b sseg=%b", pos - 1, an, sseg, exp_an, exp_sseg);
            end
            p = pos - 1;
            t = p % D;
            d = (p / D) % 4;
            if (p / FRAME == 1) begin
                checks++;
                if (t < BC && (an !== 4'hF || sseg !== 7'h7F)) begin
                    errors++;
                    $display("[TB] FAIL scan_blank pos=%0d an=%b sseg=%b expected an=1111 sseg=1111111", p, an, sseg);
                end
                if (t >= BC && (an !== lit_an[d] || sseg !== lit_seg[d])) begin
                    errors++;
                    $display("[TB] FAIL scan_order pos=%0d an=%b sseg=%b expected an=%b sseg=%b", p, an, sseg, lit_an[d], lit_seg[d]);
                end
            end
        end
    endtask

    task automatic test_snapshot_integrity();
        int p, t, d, change_frame;
        for (int k = 0; k < 2 * FRAME && (pos % FRAME) != 2 * D; k++) @(negedge clk);
        checks++;
        if ((pos % FRAME) != 2 * D) begin
            errors++;
            $display("[TB] FAIL snap_sync pos=%0d expected digit 2 start", pos);
        end
        change_frame = pos / FRAME;
        energy = 3'd3;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || sseg !== exp_sseg) begin
                errors++;
                $display("[TB] FAIL snap_model pos=%0d an=%b sseg=%b expected an=%b sseg=%b", pos - 1, an, sseg, exp_an, exp_sseg);
            end
            p = pos - 1;
            t = p % D;
            d = (p / D) % 4;
            if (p / FRAME == change_frame + 1 && d == 1 && t >= BC) begin
                checks++;
                if (an !== 4'b1101 || sseg !== 7'b0000110) begin
                    errors++;
                    $display("[TB] FAIL snap_new_energy pos=%0d an=%b sseg=%b expected an=1101 sseg=0000110", p, an, sseg);
                end
            end
        end
    endtask

    task automatic test_mid_slot_reset();
        for (int k = 0; k < 2 * FRAME && (pos % FRAME) != 2 * D + 5; k++) @(negedge clk);
        checks++;
        if ((pos % FRAME) != 2 * D + 5) begin
            errors++;
            $display("[TB] FAIL midrst_sync pos=%0d expected digit 2 tick 5", pos);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || sseg !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL midrst_outputs an=%b sseg=%b expected an=1111 sseg=1111111", an, sseg);
        end
        rst = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || sseg !== exp_sseg) begin
                errors++;
                $display("[TB] FAIL midrst_model pos=%0d an=%b sseg=%b expected an=%b sseg=%b", pos - 1, an, sseg, exp_an, exp_sseg);
            end
            checks++;
            if (an !== 4'hF && sseg !== 7'b0000001) begin
                errors++;
                $display("[TB] FAIL midrst_zero pos=%0d sseg=%b expected sseg=0000001", pos - 1, sseg);
            end
            if (k == BC + 1) begin
                checks++;
                if (an !== 4'b1110) begin
                    errors++;
                    $display("[TB] FAIL midrst_restart an=%b expected an=1110", an);
                end
            end
        end
    endtask

    task automatic test_blink();
        int p, t, d, fr;
        bit lit_expected;
        state = 4'h0; energy = 3'd1; hunger = 3'd0; entertainment = 3'd4;
        for (int k = 0; k < 7 * FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || sseg !== exp_sseg) begin
                errors++;
                $display("[TB] FAIL blink_model pos=%0d an=%b sseg=%b expected an=%b sseg=%b", pos - 1, an, sseg, exp_an, exp_sseg);
            end
            p  = pos - 1;
            t  = p % D;
            d  = (p / D) % 4;
            fr = p / FRAME;
            if (fr >= 2 && t >= BC && d == 0) begin
                checks++;
                if (an !== 4'b1110 || sseg !== 7'b0000001) begin
                    errors++;
                    $display("[TB] FAIL blink_state_lit pos=%0d an=%b sseg=%b expected an=1110 sseg=0000001", p, an, sseg);
                end
            end
            if (fr >= 2 && t >= BC && d == 2) begin
`ifdef SSEG_BLINK_EN
                lit_expected = ((fr / BF) % 2) == 0;
`else
                lit_expected = 1'b1;
`endif
                checks++;
                if (lit_expected && (an !== 4'b1011 || sseg !== 7'b0000001)) begin
                    errors++;
                    $display("[TB] FAIL blink_hunger_lit pos=%0d an=%b sseg=%b expected an=1011 sseg=0000001", p, an, sseg);
                end
                if (!lit_expected && (an !== 4'hF || sseg !== 7'h7F)) begin
                    errors++;
                    $display("[TB] FAIL blink_hunger_dark pos=%0d an=%b sseg=%b expected an=1111 sseg=1111111", p, an, sseg);
                end
            end
        end
    endtask

    task automatic test_one_hot_random();
        for (int k = 0; k < 1000 * FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (!(an inside {4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
                errors++;
                $display("[TB] FAIL one_hot pos=%0d an=%b expected at most one low bit", pos - 1, an);
            end
            checks++;
            if (an !== exp_an || sseg !== exp_sseg) begin
                errors++;
                $display("[TB] FAIL random_model pos=%0d an=%b sseg=%b expected an=%b sseg=%b", pos - 1, an, sseg, exp_an, exp_sseg);
            end
            if ($urandom_range(0, 15) == 0) begin
                state         = 4'($urandom_range(0, 15));
                energy        = 3'($urandom_range(0, 7));
                hunger        = 3'($urandom_range(0, 7));
                entertainment = 3'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_snapshot_integrity();
        test_mid_slot_reset();
        test_blink();
        test_one_hot_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
